// File: rtl/text_renderer.sv
// text_renderer: character stream to 240x64 monochrome framebuffer renderer using a 5x7 font ROM
module text_renderer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [6:0]  font_char,
  output logic [2:0]  font_col,
  input  logic [7:0]  font_pixels,
  output logic        fb_we,
  output logic [10:0] fb_addr,
  output logic [7:0]  fb_data,
  input  logic        fb_ready,
  output logic [5:0]  cursor_col,
  output logic [2:0]  cursor_row
);
  typedef enum logic [2:0] {CLEAR_ALL, IDLE, FETCH, WRITE, CLEAR_ROW} state_t;
  state_t      state_q, state_d;
  logic        init_q, init_d;
  logic        gap_q, gap_d;
  logic [6:0]  char_q, char_d;
  logic [2:0]  c_q, c_d;
  logic [10:0] addr_q, addr_d;
  logic [5:0]  col_q, col_d;
  logic [2:0]  row_q, row_d;
  logic [10:0] row_base, base;
  logic        printable;
  assign row_base   = {8'd0, row_q} * 11'd240;
  assign base       = row_base + {5'd0, col_q} * 11'd6;
  assign printable  = in_data >= 8'h20 && in_data <= 8'h7E;
  assign in_ready   = state_q == IDLE && !init_q && !gap_q;
  assign fb_we      = state_q == WRITE || state_q == CLEAR_ALL || state_q == CLEAR_ROW;
  assign fb_addr    = addr_q;
  assign fb_data    = state_q == WRITE ? font_pixels : 8'h00;
  assign font_char  = char_q;
  assign font_col   = c_q;
  assign cursor_col = col_q;
  assign cursor_row = row_q;
  // state register; reset parks in IDLE with init pending so the first free edge starts the full clear
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      init_q  <= 1'b1;
      gap_q   <= 1'b0;
      char_q  <= 7'h20;
      c_q     <= 3'd0;
      addr_q  <= 11'd0;
      col_q   <= 6'd0;
      row_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      init_q  <= init_d;
      gap_q   <= gap_d;
      char_q  <= char_d;
      c_q     <= c_d;
      addr_q  <= addr_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end
  // next-state: byte decode in IDLE, glyph column loop, clears; the 3-bit row add wraps 7 -> 0 on its own
  always_comb begin
    state_d = state_q;
    init_d  = init_q;
    gap_d   = 1'b0;
    char_d  = char_q;
    c_d     = c_q;
    addr_d  = addr_q;
    col_d   = col_q;
    row_d   = row_q;
    case (state_q)
      IDLE: begin
        if (init_q) begin
          state_d = CLEAR_ALL;
          addr_d  = 11'd0;
          init_d  = 1'b0;
        end else if (in_valid && in_ready) begin
          gap_d = 1'b1;
          if (printable) begin
            char_d  = in_data[6:0];
            c_d     = 3'd0;
            addr_d  = base;
            state_d = FETCH;
          end else if (in_data == 8'h0A) begin
            col_d   = 6'd0;
            row_d   = row_q + 3'd1;
            addr_d  = row_q == 3'd7 ? 11'd0 : addr_q;
            state_d = row_q == 3'd7 ? CLEAR_ROW : IDLE;
          end else if (in_data == 8'h0D) begin
            col_d = 6'd0;
          end else if (in_data == 8'h08) begin
            col_d = col_q == 6'd0 ? 6'd0 : col_q - 6'd1;
          end else if (in_data == 8'h0C) begin
            col_d   = 6'd0;
            row_d   = 3'd0;
            addr_d  = 11'd0;
            state_d = CLEAR_ALL;
          end
        end
      end
      FETCH: state_d = WRITE;
      WRITE: begin
        if (fb_ready) begin
          if (c_q != 3'd5) begin
            c_d     = c_q + 3'd1;
            addr_d  = addr_q + 11'd1;
            state_d = FETCH;
          end else begin
            col_d   = col_q == 6'd39 ? 6'd0 : col_q + 6'd1;
            row_d   = col_q == 6'd39 ? row_q + 3'd1 : row_q;
            addr_d  = col_q == 6'd39 && row_q == 3'd7 ? 11'd0 : addr_q;
            state_d = col_q == 6'd39 && row_q == 3'd7 ? CLEAR_ROW : IDLE;
          end
        end
      end
      CLEAR_ALL: begin
        if (fb_ready) begin
          addr_d  = addr_q == 11'd1919 ? addr_q : addr_q + 11'd1;
          state_d = addr_q == 11'd1919 ? IDLE : CLEAR_ALL;
        end
      end
      CLEAR_ROW: begin
        if (fb_ready) begin
          addr_d  = addr_q == row_base + 11'd239 ? addr_q : addr_q + 11'd1;
          state_d = addr_q == row_base + 11'd239 ? IDLE : CLEAR_ROW;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_text_renderer.sv
// tb_text_renderer: randomized and directed checks of text_renderer against a queue-based screen model
module tb_text_renderer;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic [6:0]  font_char;
  logic [2:0]  font_col;
  logic [7:0]  font_pixels = 8'h00;
  logic        fb_we;
  logic [10:0] fb_addr;
  logic [7:0]  fb_data;
  logic        fb_ready;
  logic        rdy_dir = 1'b1;
  logic        rnd = 1'b0;
  logic        rnd_rdy = 1'b1;
  logic [5:0]  cursor_col;
  logic [2:0]  cursor_row;

  text_renderer dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .font_char(font_char), .font_col(font_col), .font_pixels(font_pixels),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data), .fb_ready(fb_ready),
    .cursor_col(cursor_col), .cursor_row(cursor_row)
  );

  always #5 clk = ~clk;
  assign fb_ready = rnd ? rnd_rdy : rdy_dir;
  always @(posedge clk) rnd_rdy <= ($urandom_range(0, 3) != 0);

  // font ROM stand-in: registered, column 5 blank
  function automatic logic [7:0] rom(input logic [6:0] ch, input int col);
    logic [7:0] a, b;
    if (col >= 5) return 8'h00;
    a = {1'b0, ch} * 8'd37;
    b = 8'(col) * 8'd91;
    return a ^ b ^ 8'h5A;
  endfunction
  always @(posedge clk) font_pixels <= rom(font_char, int'(font_col));

  typedef struct { int a; logic [7:0] d; } wr_t;
  wr_t        q[$];
  int         m_col = 0, m_row = 0;
  logic       pend = 1'b1;
  int         compared = 0, mismatched = 0;
  int         wr_cnt = 0;
  int         hits[1920];
  logic [7:0] mem[1920];
  logic       acc_prev = 1'b0, stall = 1'b0;
  int         st_a = 0, st_d = 0;

  task automatic chk(input string nm, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push_clear(input int base, input int n);
    for (int i = 0; i < n; i++) q.push_back('{base + i, 8'h00});
  endtask

  task automatic row_adv();
    if (m_row < 7) m_row++;
    else begin
      m_row = 0;
      push_clear(0, 240);
    end
  endtask

  task automatic apply(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      for (int c = 0; c < 6; c++) q.push_back('{m_row * 240 + m_col * 6 + c, rom(b[6:0], c)});
      if (m_col < 39) m_col++;
      else begin
        m_col = 0;
        row_adv();
      end
    end else if (b == 8'h0A) begin
      m_col = 0;
      row_adv();
    end else if (b == 8'h0D) m_col = 0;
    else if (b == 8'h08) begin
      if (m_col > 0) m_col--;
    end else if (b == 8'h0C) begin
      m_col = 0;
      m_row = 0;
      push_clear(0, 1920);
    end
  endtask

  // compare process: sampled on the falling edge, where every handshake of the next rising edge is settled
  always @(negedge clk) begin
    wr_t w;
    if (!reset_n) begin
      q.delete();
      m_col = 0;
      m_row = 0;
      pend = 1'b1;
      stall = 1'b0;
      acc_prev = 1'b0;
    end else begin
      if (pend) begin
        push_clear(0, 1920);
        pend = 1'b0;
      end
      if (acc_prev) chk("ready_gap", int'(in_ready), 0);
      acc_prev = 1'b0;
      if (stall) begin
        chk("stall_we", int'(fb_we), 1);
        chk("stall_addr", int'(fb_addr), st_a);
        chk("stall_data", int'(fb_data), st_d);
      end
      stall = fb_we && !fb_ready;
      st_a = int'(fb_addr);
      st_d = int'(fb_data);
      if (in_ready) begin
        chk("idle_pending_writes", q.size(), 0);
        chk("cursor_col", int'(cursor_col), m_col);
        chk("cursor_row", int'(cursor_row), m_row);
      end
      if (fb_we && fb_ready) begin
        wr_cnt++;
        if (fb_addr < 11'd1920) begin
          hits[fb_addr]++;
          mem[fb_addr] = fb_data;
        end
        if (q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_write: addr %0d data %0d, expected no write", fb_addr, fb_data);
        end else begin
          w = q.pop_front();
          chk("wr_addr", int'(fb_addr), w.a);
          chk("wr_data", int'(fb_data), int'(w.d));
        end
      end
      if (in_valid && in_ready) begin
        apply(in_data);
        acc_prev = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (n < 8000) begin
      tick();
      n++;
      if (in_ready) break;
    end
    chk("idle_reached", int'(in_ready), 1);
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    while (!in_ready && n < 8000) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      compared++;
      mismatched++;
      $display("FAIL send_timeout: in_ready 0, expected 1");
    end else begin
      in_valid = 1'b1;
      in_data = b;
      tick();
      in_valid = 1'b0;
    end
  endtask

  logic [7:0] ctl[9] = '{8'h0D, 8'h08, 8'h1B, 8'h00, 8'h7F, 8'hFF, 8'h0C, 8'h09, 8'h80};

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int n, w0, h8, k, r;
    repeat (3) tick();
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_fb_we", int'(fb_we), 0);
    chk("rst_fb_addr", int'(fb_addr), 0);
    chk("rst_fb_data", int'(fb_data), 0);
    chk("rst_font_char", int'(font_char), 32);
    chk("rst_font_col", int'(font_col), 0);
    chk("rst_cursor_col", int'(cursor_col), 0);
    chk("rst_cursor_row", int'(cursor_row), 0);
    chk("rom_pin_41_0", int'(rom(7'h41, 0)), 8'h3F);
    reset_n = 1'b1;
    w0 = wr_cnt;
    wait_idle(n);
    chk("clear_all_writes", wr_cnt - w0, 1920);
    chk("clear_all_cursor", int'({cursor_row, cursor_col}), 0);
    send(8'h41);
    wait_idle(n);
    chk("glyph_latency", n, 12);
    chk("glyph_font_char", int'(font_char), 8'h41);
    chk("glyph_mem0", int'(mem[0]), 8'h3F);
    chk("glyph_mem1", int'(mem[1]), 8'h64);
    chk("glyph_mem5", int'(mem[5]), 0);
    chk("glyph_cursor_col", int'(cursor_col), 1);
    h8 = hits[8];
    send(8'h42);
    k = 0;
    while (!(fb_we && fb_addr == 11'd8) && k < 50) begin
      tick();
      k++;
    end
    chk("stall_reach_addr", int'(fb_addr), 8);
    rdy_dir = 1'b0;
    repeat (3) tick();
    rdy_dir = 1'b1;
    wait_idle(n);
    chk("stall_single_write", hits[8] - h8, 1);
    for (int i = 0; i < 38; i++) send(8'h30 + 8'(i % 10));
    send(8'h42);
    wait_idle(n);
    chk("wrap_cursor_row", int'(cursor_row), 1);
    chk("wrap_cursor_col", int'(cursor_col), 1);
    chk("wrap_mem240", int'(mem[240]), 8'hD0);
    chk("wrap_mem245", int'(mem[245]), 0);
    repeat (6) send(8'h0A);
    wait_idle(n);
    chk("row7_reached", int'(cursor_row), 7);
    w0 = wr_cnt;
    send(8'h0A);
    wait_idle(n);
    chk("row_clear_writes", wr_cnt - w0, 240);
    chk("row_clear_cursor", int'({cursor_row, cursor_col}), 0);
    send(8'h08);
    wait_idle(n);
    chk("bs_at_zero", int'(cursor_col), 0);
    w0 = wr_cnt;
    send(8'h1B);
    chk("esc_gap", int'(in_ready), 0);
    tick();
    chk("esc_back", int'(in_ready), 1);
    chk("esc_no_write", wr_cnt - w0, 0);
    send(8'h5A);
    send(8'h0A);
    w0 = wr_cnt;
    send(8'h0C);
    wait_idle(n);
    chk("ff_writes", wr_cnt - w0, 1920);
    chk("ff_cursor", int'({cursor_row, cursor_col}), 0);
    rnd = 1'b1;
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 99);
      if (r < 70) send(8'($urandom_range(32, 126)));
      else if (r < 82) send(8'h0A);
      else send(ctl[$urandom_range(0, 8)]);
    end
    wait_idle(n);
    rnd = 1'b0;
    send(8'h55);
    repeat (4) tick();
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    w0 = wr_cnt;
    wait_idle(n);
    chk("midreset_clear_writes", wr_cnt - w0, 1920);
    chk("midreset_cursor", int'({cursor_row, cursor_col}), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
